// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

    // Controller states: accept operands, step through digits, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select encoding on the sub input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple slice. Also exposes the carry into its top
// bit so the caller can form signed overflow on the most significant digit.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    // Ripple chain: bit i consumes carry i and produces carry i+1.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout     = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor behind a valid/ready handshake.
// One DIGIT-bit slice is reused NDIG times; the carry lives in a register
// between digits. Subtraction b - a is done as b + ~a + 1.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $error("addsub_serial: DIGIT must be in 1..WIDTH");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_ratio
        $error("addsub_serial: WIDTH must be a multiple of DIGIT");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;      // addend, already inverted when subtracting
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;    // partial result, filled from the top
    logic             r_carry;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    // With a single digit there is nothing left to shift; the slice result is
    // the whole word.
    if (NDIG == 1) begin : g_one_digit
        assign w_a_nxt   = '0;
        assign w_b_nxt   = '0;
        assign w_acc_nxt = w_sum;
    end else begin : g_multi_digit
        assign w_a_nxt   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
        assign w_b_nxt   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:DIGIT]};
    end

    assign w_last = (r_cnt == CW'(NDIG - 1));

    // Control FSM plus datapath registers; results only move on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= (sub == MODE_SUB) ? ~a : a;
                        r_b     <= b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= w_a_nxt;
                    r_b     <= w_b_nxt;
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s     <= w_acc_nxt;
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ w_cmsb;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed table and corner sequences on a 16x4
// instance, plus random streams on 16x1, 16x16 and 32x8 instances checked
// against an integer-arithmetic reference.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        of;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        of;
    } vec_t;

    // ---------------- directed instance: WIDTH=16, DIGIT=4 ----------------
    logic        rst0, iv0, ir0, sb0, ov0, or0, co0, of0;
    logic [15:0] a0, b0, s0;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .sub(sb0), .out_valid(ov0), .out_ready(or0),
        .s(s0), .c_out(co0), .ovf(of0)
    );

    // ---------------- random instances ----------------
    logic rst_r;

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int WL = (g == 2) ? 32 : 16;
        localparam int DL = (g == 0) ? 1 : (g == 1) ? 16 : 8;
        localparam int NL = WL / DL;
        localparam int NOPS = 2000;

        logic          iv, ir, sb, ov, orr, co, of;
        logic [WL-1:0] ai, bi, so;
        bit            done_f = 1'b0;

        addsub_serial #(.WIDTH(WL), .DIGIT(DL)) u_dut (
            .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir),
            .a(ai), .b(bi), .sub(sb), .out_valid(ov), .out_ready(orr),
            .s(so), .c_out(co), .ovf(of)
        );

        function automatic logic [WL-1:0] rop();
            logic [31:0] r;
            r = $urandom;
            case ($urandom % 8)
                0: r = 32'h0;
                1: r = 32'hFFFF_FFFF;
                2: r = 32'h1 << (WL - 1);
                3: r = (32'h1 << (WL - 1)) - 32'h1;
                default: ;
            endcase
            return r[WL-1:0];
        endfunction

        // Reference: plain integer arithmetic on unsigned and signed views.
        function automatic exp_t model(logic [WL-1:0] x, logic [WL-1:0] y,
                                       logic m, int acc);
            exp_t   e;
            longint md, h, ux, uy, sx, sy, ur, sr;
            md = longint'(1) << WL;
            h  = md / 2;
            ux = longint'(x);
            uy = longint'(y);
            sx = (ux >= h) ? ux - md : ux;
            sy = (uy >= h) ? uy - md : uy;
            if (!m) begin
                ur = ux + uy;
                sr = sx + sy;
            end else begin
                ur = uy - ux + md;   // >= md exactly when there is no borrow
                sr = sy - sx;
            end
            e.s   = 32'(ur % md);
            e.co  = (ur >= md);
            e.of  = (sr >= h) || (sr < -h);
            e.acc = acc;
            return e;
        endfunction

        initial begin : stim
            exp_t          q[$];
            exp_t          e;
            int            cyc, issued, prev_acc;
            logic [WL-1:0] pa, pb;
            logic          psub;
            string         tag;
            cyc = 0; issued = 0; prev_acc = -1;
            iv = 1'b0; ai = '0; bi = '0; sb = 1'b0; orr = 1'b1;
            tag = $sformatf("w%0dd%0d", WL, DL);
            pa = rop(); pb = rop(); psub = 1'b0;
            do @(negedge clk); while (rst_r);
            while (!(issued == NOPS && q.size() == 0) && cyc < NOPS * (NL + 2) + 200) begin
                if (ov) begin
                    if (q.size() == 0) begin
                        chk({tag, " spurious_out_valid"}, 32'(1), 32'(0));
                    end else begin
                        e = q.pop_front();
                        chk({tag, " s"},       32'(so), e.s);
                        chk({tag, " c_out"},   32'(co), 32'(e.co));
                        chk({tag, " ovf"},     32'(of), 32'(e.of));
                        chk({tag, " latency"}, 32'(cyc - e.acc - 1), 32'(NL));
                    end
                end
                if (ir) begin
                    if (issued < NOPS) begin
                        if (prev_acc >= 0)
                            chk({tag, " interval"}, 32'(cyc - prev_acc), 32'(NL + 2));
                        q.push_back(model(pa, pb, psub, cyc));
                        iv = 1'b1; ai = pa; bi = pb; sb = psub;
                        prev_acc = cyc;
                        issued++;
                        pa = rop(); pb = rop(); psub = (issued >= NOPS / 2);
                    end else begin
                        iv = 1'b0;
                    end
                end else begin
                    // Busy: garbage on every input must be ignored.
                    iv = 1'($urandom); ai = WL'($urandom); bi = WL'($urandom);
                    sb = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
            iv = 1'b0;
            if (issued != NOPS || q.size() != 0)
                chk({tag, " stream_timeout"}, 32'(1), 32'(0));
            done_f = 1'b1;
        end
    end

    // One operation on the 16x4 instance; returns result and accept->valid edges.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                          output logic [15:0] s, output logic co, output logic of,
                          output int lat);
        int          t;
        logic [15:0] prev;
        t = 0;
        while (!ir0 && t < 50) begin @(negedge clk); t++; end
        if (!ir0) chk("wait_in_ready", 32'(ir0), 32'(1));
        prev = s0;
        iv0 = 1'b1; a0 = a; b0 = b; sb0 = sb;
        @(negedge clk);
        iv0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); sb0 = 1'($urandom);
        chk("s_hold_during_run", 32'(s0), 32'(prev));
        lat = 0;
        while (!ov0 && lat < 50) begin @(negedge clk); lat++; end
        if (!ov0) chk("out_valid_timeout", 32'(ov0), 32'(1));
        s = s0; co = co0; of = of0;
    endtask

    initial begin : main
        vec_t        tbl[8];
        logic [15:0] rs;
        logic        rco, rof;
        int          lat;
        bit          seen;

        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'h0001, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[2] = '{16'h0001, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst0 = 1'b1; rst_r = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; sb0 = 1'b0; or0 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst_r = 1'b0;

        chk("reset in_ready",  32'(ir0), 32'(1));
        chk("reset out_valid", 32'(ov0), 32'(0));
        chk("reset s",         32'(s0),  32'(0));
        chk("reset c_out",     32'(co0), 32'(0));
        chk("reset ovf",       32'(of0), 32'(0));

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sb, rs, rco, rof, lat);
            chk($sformatf("vec%0d s", i),       32'(rs),  32'(tbl[i].s));
            chk($sformatf("vec%0d c_out", i),   32'(rco), 32'(tbl[i].co));
            chk($sformatf("vec%0d ovf", i),     32'(rof), 32'(tbl[i].of));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(4));
        end

        // Back-pressure: result must hold and new operands be ignored.
        @(negedge clk);
        or0 = 1'b0;
        run_op(16'h00F0, 16'h800F, 1'b0, rs, rco, rof, lat);
        chk("hold first s", 32'(rs), 32'h80FF);
        for (int k = 0; k < 5; k++) begin
            iv0 = k[0]; a0 = 16'($urandom); b0 = 16'($urandom); sb0 = 1'($urandom);
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", k), 32'(ov0), 32'(1));
            chk($sformatf("hold%0d in_ready", k),  32'(ir0), 32'(0));
            chk($sformatf("hold%0d s", k),         32'(s0),  32'h80FF);
            chk($sformatf("hold%0d flags", k),     32'({co0, of0}), 32'(2'b00));
        end
        iv0 = 1'b0; or0 = 1'b1;
        @(negedge clk);
        chk("release in_ready",  32'(ir0), 32'(1));
        chk("release out_valid", 32'(ov0), 32'(0));
        chk("s kept in idle",    32'(s0),  32'h80FF);
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (ov0) seen = 1'b1; end
        chk("no ghost accept", 32'(seen), 32'(0));

        // Reset during the second RUN cycle aborts the operation.
        iv0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; sb0 = 1'b0;
        @(negedge clk);
        iv0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("abort in_ready",  32'(ir0), 32'(1));
        chk("abort out_valid", 32'(ov0), 32'(0));
        chk("abort s",         32'(s0),  32'(0));
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (ov0) seen = 1'b1; end
        chk("abort no result", 32'(seen), 32'(0));
        run_op(16'h0003, 16'h0004, 1'b0, rs, rco, rof, lat);
        chk("post-abort s",       32'(rs),  32'h0007);
        chk("post-abort latency", 32'(lat), 32'(4));

        // Let the random streams finish.
        begin
            int t;
            t = 0;
            while (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f) && t < 60000) begin
                @(negedge clk); t++;
            end
            if (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f))
                chk("random streams timeout", 32'(0), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
